// File: rtl/net_bus_tx7_if.sv
// NetBus bus bundle for the 7-port transmit router: one input beat stream
// and seven registered output streams sharing a broadcast data bus.
interface net_bus_tx7_if #(
  parameter int DATA_WIDTH = 4
);
  localparam int W = DATA_WIDTH*9 + 14;

  logic [W-1:0] TDATA;
  logic         TVALID;
  logic         TREADY;

  logic [W-1:0] TDATA0, TDATA1, TDATA2, TDATA3, TDATA4, TDATA5, TDATA6;
  logic         TVALID0, TVALID1, TVALID2, TVALID3, TVALID4, TVALID5, TVALID6;
  logic         TREADY0, TREADY1, TREADY2, TREADY3, TREADY4, TREADY5, TREADY6;

  // Router side: sinks the input stream, sources the seven port streams.
  modport slave (
    input  TDATA, TVALID,
    input  TREADY0, TREADY1, TREADY2, TREADY3, TREADY4, TREADY5, TREADY6,
    output TREADY,
    output TDATA0, TDATA1, TDATA2, TDATA3, TDATA4, TDATA5, TDATA6,
    output TVALID0, TVALID1, TVALID2, TVALID3, TVALID4, TVALID5, TVALID6
  );

  // Frame source and per-port transmit slices.
  modport master (
    output TDATA, TVALID,
    output TREADY0, TREADY1, TREADY2, TREADY3, TREADY4, TREADY5, TREADY6,
    input  TREADY,
    input  TDATA0, TDATA1, TDATA2, TDATA3, TDATA4, TDATA5, TDATA6,
    input  TVALID0, TVALID1, TVALID2, TVALID3, TVALID4, TVALID5, TVALID6
  );
endinterface

// File: rtl/net_bus_tx7.sv
// NetBus transmit router: steers whole frames to one of seven ports using the
// route code of the first beat; unmapped frames are dropped and counted.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a frame's first beat; route code decoded here
// FWD     | forwarding the remaining beats of a frame to cur_port
// DROP    | discarding the remaining beats of an unmapped frame
module net_bus_tx7 #(
  parameter int          DATA_WIDTH = 4,
  parameter logic [31:0] PORT_ROUTE = 32'h76543210
) (
  input  logic          CLK,
  input  logic          RESET,
  net_bus_tx7_if.slave  bus,
  output logic [15:0]   DROP_COUNT
);
  localparam int W = DATA_WIDTH*9 + 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   cur_port_q, cur_port_d;
  logic [W-1:0] obuf_data_q, obuf_data_d;
  logic         obuf_valid_q, obuf_valid_d;
  logic [2:0]   obuf_port_q, obuf_port_d;
  logic [15:0]  drop_cnt_q, drop_cnt_d;

  logic         in_last;
  logic [2:0]   in_code;
  logic [3:0]   dest;
  logic         dest_drop;
  logic [7:0]   tready_vec;
  logic         sel_ready;
  logic         drain;
  logic         can_load;
  logic         in_ready;
  logic         accept;
  logic         load;
  logic [2:0]   load_port;

  // Input decode and ready generation.
  always_comb begin
    in_last    = bus.TDATA[0];
    in_code    = bus.TDATA[3:1];
    dest       = PORT_ROUTE[{in_code, 2'b00} +: 4];
    dest_drop  = (dest > 4'd6);
    tready_vec = {1'b0, bus.TREADY6, bus.TREADY5, bus.TREADY4, bus.TREADY3,
                  bus.TREADY2, bus.TREADY1, bus.TREADY0};
    sel_ready  = tready_vec[obuf_port_q];
    drain      = obuf_valid_q & sel_ready;
    can_load   = ~obuf_valid_q | sel_ready;

    in_ready = can_load;
    case (state_q)
      ST_DROP: in_ready = 1'b1;
      ST_IDLE: in_ready = dest_drop | can_load;
      default: in_ready = can_load;
    endcase

    accept = bus.TVALID & in_ready;
  end

  // Next-state, obuf and drop counter.
  always_comb begin
    state_d      = state_q;
    cur_port_d   = cur_port_q;
    obuf_data_d  = obuf_data_q;
    obuf_valid_d = obuf_valid_q;
    obuf_port_d  = obuf_port_q;
    drop_cnt_d   = drop_cnt_q;
    load         = 1'b0;
    load_port    = cur_port_q;

    if (drain) begin
      obuf_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!dest_drop) begin
            load       = 1'b1;
            load_port  = dest[2:0];
            cur_port_d = dest[2:0];
            if (!in_last) begin
              state_d = ST_FWD;
            end
          end else begin
            if (drop_cnt_q != 16'hFFFF) begin
              drop_cnt_d = drop_cnt_q + 16'd1;
            end
            if (!in_last) begin
              state_d = ST_DROP;
            end
          end
        end
      end
      ST_FWD: begin
        if (accept) begin
          load = 1'b1;
          if (in_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (accept && in_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A load on the same edge as a drain overrides the clear: full throughput.
    if (load) begin
      obuf_data_d  = bus.TDATA;
      obuf_valid_d = 1'b1;
      obuf_port_d  = load_port;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      cur_port_q   <= 3'd0;
      obuf_data_q  <= '0;
      obuf_valid_q <= 1'b0;
      obuf_port_q  <= 3'd0;
      drop_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      cur_port_q   <= cur_port_d;
      obuf_data_q  <= obuf_data_d;
      obuf_valid_q <= obuf_valid_d;
      obuf_port_q  <= obuf_port_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.TREADY = in_ready;

  assign bus.TDATA0 = obuf_data_q;
  assign bus.TDATA1 = obuf_data_q;
  assign bus.TDATA2 = obuf_data_q;
  assign bus.TDATA3 = obuf_data_q;
  assign bus.TDATA4 = obuf_data_q;
  assign bus.TDATA5 = obuf_data_q;
  assign bus.TDATA6 = obuf_data_q;

  assign bus.TVALID0 = obuf_valid_q & (obuf_port_q == 3'd0);
  assign bus.TVALID1 = obuf_valid_q & (obuf_port_q == 3'd1);
  assign bus.TVALID2 = obuf_valid_q & (obuf_port_q == 3'd2);
  assign bus.TVALID3 = obuf_valid_q & (obuf_port_q == 3'd3);
  assign bus.TVALID4 = obuf_valid_q & (obuf_port_q == 3'd4);
  assign bus.TVALID5 = obuf_valid_q & (obuf_port_q == 3'd5);
  assign bus.TVALID6 = obuf_valid_q & (obuf_port_q == 3'd6);

  assign DROP_COUNT = drop_cnt_q;
endmodule

// File: tb/tb_net_bus_tx7.sv
// Scoreboard bench for net_bus_tx7: expected beats are queued as the source
// hands them over and popped as the port sinks take them.
module tb_net_bus_tx7;
  localparam int W = 4*9 + 14;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] DROP_COUNT;
  logic [6:0]  rdy = 7'h7F;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  typedef struct {
    int           port;
    logic [W-1:0] data;
    int           stamp;
    bit           lat;
  } exp_t;
  exp_t q[$];

  net_bus_tx7_if #(.DATA_WIDTH(4)) bus();

  net_bus_tx7 #(.DATA_WIDTH(4), .PORT_ROUTE(32'hF6543210)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .DROP_COUNT(DROP_COUNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign bus.TREADY0 = rdy[0];
  assign bus.TREADY1 = rdy[1];
  assign bus.TREADY2 = rdy[2];
  assign bus.TREADY3 = rdy[3];
  assign bus.TREADY4 = rdy[4];
  assign bus.TREADY5 = rdy[5];
  assign bus.TREADY6 = rdy[6];

  logic [6:0]   tv;
  logic [W-1:0] od [7];
  assign tv = {bus.TVALID6, bus.TVALID5, bus.TVALID4, bus.TVALID3,
               bus.TVALID2, bus.TVALID1, bus.TVALID0};
  assign od[0] = bus.TDATA0;
  assign od[1] = bus.TDATA1;
  assign od[2] = bus.TDATA2;
  assign od[3] = bus.TDATA3;
  assign od[4] = bus.TDATA4;
  assign od[5] = bus.TDATA5;
  assign od[6] = bus.TDATA6;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor, sampled just before each rising edge.
  logic [6:0]   prev_v = '0;
  logic [6:0]   prev_r = '0;
  logic [W-1:0] prev_d = '0;

  task automatic mon_step();
    exp_t e;
    if (RESET) begin
      prev_v = '0;
      return;
    end
    chk("onehot", 64'($countones(tv) <= 1), 64'd1);
    for (int k = 0; k < 7; k++) begin
      if (prev_v[k] && !prev_r[k]) begin
        chk("hold_valid", 64'(tv[k]), 64'd1);
        chk("hold_data", 64'(od[k]), 64'(prev_d));
      end
    end
    for (int k = 0; k < 7; k++) begin
      if (tv[k] && rdy[k]) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          chk("port", 64'(k), 64'(e.port));
          chk("data", 64'(od[k]), 64'(e.data));
          if (e.lat) chk("latency", 64'(cyc), 64'(e.stamp + 1));
        end
      end
    end
    prev_v = tv;
    prev_r = rdy;
    prev_d = od[0];
  endtask

  always begin
    @(negedge CLK);
    #4;
    mon_step();
  end

  // port < 0 means the frame is expected to be dropped.
  task automatic send_frame(input int code, input int n, input int port,
                            input bit last_end, input bit lat);
    logic [W-1:0] d;
    exp_t e;
    int tries;
    for (int i = 0; i < n; i++) begin
      d = W'({$urandom, $urandom});
      d[0] = (i == n - 1) && last_end;
      if (i == 0) d[3:1] = 3'(code);
      tries = 0;
      forever begin
        @(negedge CLK);
        bus.TVALID = 1'b1;
        bus.TDATA  = d;
        #1;
        if (port < 0) chk("drop_tready", 64'(bus.TREADY), 64'd1);
        if (bus.TREADY) break;
        tries++;
        if (tries > 100) begin
          chk("accept_timeout", 64'(tries), 64'd0);
          bus.TVALID = 1'b0;
          return;
        end
      end
      if (lat) chk("no_bubble", 64'(tries), 64'd0);
      if (port >= 0) begin
        e.port = port; e.data = d; e.stamp = cyc; e.lat = lat;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle_in();
    @(negedge CLK);
    bus.TVALID = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge CLK);
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    bus.TVALID = 1'b0;
    bus.TDATA  = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #3;
    chk("rst_tvalid", 64'(tv), 64'd0);
    chk("rst_tdata", 64'(od[0]), 64'd0);
    chk("rst_drop", 64'(DROP_COUNT), 64'd0);
    chk("rst_tready", 64'(bus.TREADY), 64'd1);

    // Basic routing, 1-cycle latency at full rate.
    send_frame(2, 3, 2, 1'b1, 1'b1);
    idle_in();
    wait_drain();

    // Dropped frame then a code-0 frame.
    send_frame(7, 4, -1, 1'b1, 1'b0);
    idle_in();
    #3 chk("drop_count_1", 64'(DROP_COUNT), 64'd1);
    send_frame(0, 2, 0, 1'b1, 1'b0);
    idle_in();
    wait_drain();

    // Backpressure in the middle of a port-1 frame.
    fork
      send_frame(1, 6, 1, 1'b1, 1'b0);
      begin
        repeat (3) @(negedge CLK);
        rdy[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge CLK);
          #1 chk("bp_tready", 64'(bus.TREADY), 64'd0);
        end
        @(negedge CLK);
        rdy[1] = 1'b1;
      end
    join
    idle_in();
    wait_drain();

    // Back-to-back frames to one port with no bubble.
    send_frame(6, 2, 6, 1'b1, 1'b1);
    send_frame(6, 1, 6, 1'b1, 1'b1);
    send_frame(6, 3, 6, 1'b1, 1'b1);
    idle_in();
    wait_drain();

    // Port switch while the previous port is stalled.
    @(negedge CLK);
    rdy[4] = 1'b0;
    fork
      begin
        send_frame(4, 1, 4, 1'b1, 1'b0);
        send_frame(5, 2, 5, 1'b1, 1'b0);
        idle_in();
      end
      begin
        repeat (5) @(negedge CLK);
        rdy[4] = 1'b1;
      end
    join
    wait_drain();

    // Reset mid-frame with a beat held in obuf.
    rdy[1] = 1'b0;
    send_frame(1, 1, 1, 1'b0, 1'b0);
    @(negedge CLK);
    bus.TVALID = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    q.delete();
    rdy[1] = 1'b1;
    #3;
    chk("mid_rst_tvalid", 64'(tv), 64'd0);
    chk("mid_rst_tdata", 64'(od[1]), 64'd0);
    chk("mid_rst_drop", 64'(DROP_COUNT), 64'd0);
    send_frame(3, 1, 3, 1'b1, 1'b0);
    idle_in();
    wait_drain();

    // Drop counter saturation with single-beat unmapped frames.
    @(negedge CLK);
    bus.TDATA  = W'(4'hF);
    bus.TVALID = 1'b1;
    #1 chk("sat_tready", 64'(bus.TREADY), 64'd1);
    repeat (10) @(negedge CLK);
    #1 chk("sat_cnt_10", 64'(DROP_COUNT), 64'd10);
    repeat (65524) @(negedge CLK);
    #1 chk("sat_cnt_fffe", 64'(DROP_COUNT), 64'hFFFE);
    @(negedge CLK);
    #1 chk("sat_cnt_ffff", 64'(DROP_COUNT), 64'hFFFF);
    repeat (2) @(negedge CLK);
    bus.TVALID = 1'b0;
    #1 chk("sat_hold", 64'(DROP_COUNT), 64'hFFFF);
    chk("sat_no_output", 64'(q.size()), 64'd0);

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
